// File: rtl/npc_sequencer.sv
// -----------------------------------------------------------------------------
// npc_sequencer
//
// Multi-cycle control FSM for the next-PC path of the multi-cycle MIPS core.
// It steps each instruction through FETCH, DECODE, EXEC, MEM and WB. It issues
// exactly one PCWr per instruction, in that instruction's final state, along
// with the NPCOp the NPC block uses for that write.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   op, funct   IR[31:26] / IR[5:0], looked at only in DECODE
//   zero        ALU zero flag, looked at only in EXEC
//   imem_ready  instruction memory data valid, looked at only in FETCH
//   PCWr        PC load strobe (PC <= NPC)
//   NPCOp       00 PLUS4, 01 BRANCH, 10 JUMP_IMM, 11 JUMP_REG
//   IRWr        IR load strobe
//   RFWr        register-file write strobe
//   DMWr        data-memory write strobe
//   illegal     one-cycle pulse on an undecodable instruction
//   state       current state code (debug)
//   retire_cnt  retired-instruction counter, only with NPC_SEQ_RETIRE_CNT_EN
//
// Optional feature macro: NPC_SEQ_RETIRE_CNT_EN
// -----------------------------------------------------------------------------
module npc_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       imem_ready,
    output logic       PCWr,
    output logic [1:0] NPCOp,
    output logic       IRWr,
    output logic       RFWr,
    output logic       DMWr,
    output logic       illegal,
    output logic [2:0] state
`ifdef NPC_SEQ_RETIRE_CNT_EN
    ,
    output logic [31:0] retire_cnt
`endif
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        C_NONE, C_RALU, C_JR, C_LW, C_SW, C_BEQ, C_BNE, C_J, C_JAL, C_IMM, C_ILL
    } cls_t;

    function automatic cls_t decode_cls(input logic [5:0] op_i, input logic [5:0] funct_i);
        cls_t c;
        c = C_ILL;
        case (op_i)
            6'b000000: begin
                case (funct_i)
                    6'b100000, 6'b100010, 6'b100100,
                    6'b100101, 6'b101010:          c = C_RALU;
                    6'b001000:                     c = C_JR;
                    default:                       c = C_ILL;
                endcase
            end
            6'b100011:                             c = C_LW;
            6'b101011:                             c = C_SW;
            6'b000100:                             c = C_BEQ;
            6'b000101:                             c = C_BNE;
            6'b000010:                             c = C_J;
            6'b000011:                             c = C_JAL;
            6'b001000, 6'b001101, 6'b001111:       c = C_IMM;
            default:                               c = C_ILL;
        endcase
        return c;
    endfunction

    state_t state_q, state_d;
    cls_t   cls_q, cls_d;
    cls_t   dec_cls;

    assign dec_cls = decode_cls(op, funct);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            cls_q   <= C_NONE;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        PCWr    = 1'b0;
        NPCOp   = 2'b00;
        IRWr    = 1'b0;
        RFWr    = 1'b0;
        DMWr    = 1'b0;
        illegal = 1'b0;

        case (state_q)
            S_FETCH: begin
                if (imem_ready) begin
                    IRWr    = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                // Class is captured here so later states ignore op/funct.
                cls_d = dec_cls;
                case (dec_cls)
                    C_J: begin
                        PCWr = 1'b1; NPCOp = 2'b10; state_d = S_FETCH;
                    end
                    C_JAL: begin
                        PCWr = 1'b1; NPCOp = 2'b10; RFWr = 1'b1; state_d = S_FETCH;
                    end
                    C_JR: begin
                        PCWr = 1'b1; NPCOp = 2'b11; state_d = S_FETCH;
                    end
                    C_ILL: begin
                        // Skip the bad word: advance PC by 4 and refetch.
                        PCWr = 1'b1; illegal = 1'b1; state_d = S_FETCH;
                    end
                    default: state_d = S_EXEC;
                endcase
            end
            S_EXEC: begin
                case (cls_q)
                    C_BEQ: begin
                        PCWr = 1'b1; NPCOp = zero ? 2'b01 : 2'b00; state_d = S_FETCH;
                    end
                    C_BNE: begin
                        PCWr = 1'b1; NPCOp = zero ? 2'b00 : 2'b01; state_d = S_FETCH;
                    end
                    C_LW, C_SW:     state_d = S_MEM;
                    C_RALU, C_IMM:  state_d = S_WB;
                    default:        state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                case (cls_q)
                    C_SW: begin
                        DMWr = 1'b1; PCWr = 1'b1; state_d = S_FETCH;
                    end
                    C_LW:    state_d = S_WB;
                    default: state_d = S_FETCH;
                endcase
            end
            S_WB: begin
                RFWr    = 1'b1;
                PCWr    = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        // Reset aborts whatever is in flight: no side effects this cycle.
        if (rst) begin
            PCWr    = 1'b0;
            NPCOp   = 2'b00;
            IRWr    = 1'b0;
            RFWr    = 1'b0;
            DMWr    = 1'b0;
            illegal = 1'b0;
            state_d = S_FETCH;
            cls_d   = C_NONE;
        end
    end

    assign state = state_q;

`ifdef NPC_SEQ_RETIRE_CNT_EN
    logic [31:0] retire_cnt_q, retire_cnt_d;

    // One PCWr per instruction, so counting PCWr counts retirements.
    always_comb retire_cnt_d = retire_cnt_q + {31'd0, PCWr};

    always_ff @(posedge clk) begin
        if (rst) retire_cnt_q <= 32'd0;
        else     retire_cnt_q <= retire_cnt_d;
    end

    assign retire_cnt = retire_cnt_q;
`endif

endmodule

// File: tb/tb_npc_sequencer.sv
module tb_npc_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] op, funct;
    logic       zero, imem_ready;
    logic       PCWr, IRWr, RFWr, DMWr, illegal;
    logic [1:0] NPCOp;
    logic [2:0] state;
`ifdef NPC_SEQ_RETIRE_CNT_EN
    logic [31:0] retire_cnt;
`endif

    npc_sequencer dut (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero),
        .imem_ready(imem_ready), .PCWr(PCWr), .NPCOp(NPCOp), .IRWr(IRWr),
        .RFWr(RFWr), .DMWr(DMWr), .illegal(illegal), .state(state)
`ifdef NPC_SEQ_RETIRE_CNT_EN
        , .retire_cnt(retire_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_retire = 0;

    // Packed per-cycle view: {state[2:0], PCWr, NPCOp[1:0], IRWr, RFWr, DMWr, illegal}
    logic [9:0] exp_q[$];

    function automatic logic [9:0] mk(input logic [2:0] st, input logic pc, input logic [1:0] np,
                                      input logic ir, input logic rf, input logic dm, input logic il);
        return {st, pc, np, ir, rf, dm, il};
    endfunction

    // Reference: expected cycle-by-cycle trace of one instruction, built from
    // the instruction's class and the list of states it visits.
    function automatic void model(input logic [5:0] o, input logic [5:0] f, input logic z, input int stalls);
        int kind;        // 0 jump/illegal, 1 branch, 2 sw, 3 alu/imm, 4 lw
        logic [1:0] np;
        logic rf, il;
        kind = 0; np = 2'b00; rf = 1'b0; il = 1'b0;
        case (o)
            6'h00: begin
                if (f == 6'h20 || f == 6'h22 || f == 6'h24 || f == 6'h25 || f == 6'h2a) kind = 3;
                else if (f == 6'h08) np = 2'b11;
                else il = 1'b1;
            end
            6'h23: kind = 4;
            6'h2b: kind = 2;
            6'h04: begin kind = 1; np = z ? 2'b01 : 2'b00; end
            6'h05: begin kind = 1; np = z ? 2'b00 : 2'b01; end
            6'h02: np = 2'b10;
            6'h03: begin np = 2'b10; rf = 1'b1; end
            6'h08, 6'h0d, 6'h0f: kind = 3;
            default: il = 1'b1;
        endcase
        exp_q.delete();
        for (int i = 0; i < stalls; i++) exp_q.push_back(mk(3'd0, 0, 2'b00, 0, 0, 0, 0));
        exp_q.push_back(mk(3'd0, 0, 2'b00, 1, 0, 0, 0));
        if (kind != 0) exp_q.push_back(mk(3'd1, 0, 2'b00, 0, 0, 0, 0));
        if (kind >= 2) exp_q.push_back(mk(3'd2, 0, 2'b00, 0, 0, 0, 0));
        if (kind == 4) exp_q.push_back(mk(3'd3, 0, 2'b00, 0, 0, 0, 0));
        case (kind)
            0: exp_q.push_back(mk(3'd1, 1, np, 0, rf, 0, il));
            1: exp_q.push_back(mk(3'd2, 1, np, 0, 0, 0, 0));
            2: exp_q.push_back(mk(3'd3, 1, 2'b00, 0, 0, 1, 0));
            default: exp_q.push_back(mk(3'd4, 1, 2'b00, 0, 1, 0, 0));
        endcase
    endfunction

    // Called at posedge+1: drive, sample at negedge, compare, advance.
    task automatic do_cycle(input logic [9:0] exp, input logic rdy, input logic z,
                            input logic [5:0] o, input logic [5:0] f, input string name,
                            output logic [9:0] got);
        imem_ready = rdy; zero = z; op = o; funct = f;
        @(negedge clk);
        got = {state, PCWr, NPCOp, IRWr, RFWr, DMWr, illegal};
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b required %b (st,pc,np,ir,rf,dm,il)", name, got, exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                             input int stalls, input string name,
                             output int obs_cyc, output logic [1:0] obs_np);
        logic [9:0] e, got;
        logic rdy, zd;
        logic [5:0] od, fd;
        model(o, f, z, stalls);
        obs_cyc = -1; obs_np = 2'bxx;
        for (int i = 0; i < exp_q.size(); i++) begin
            e  = exp_q[i];
            rdy = (e[9:7] == 3'd0) ? e[3] : 1'($urandom_range(1));
            od  = (e[9:7] == 3'd1) ? o : 6'($urandom);
            fd  = (e[9:7] == 3'd1) ? f : 6'($urandom);
            zd  = (e[9:7] == 3'd2) ? z : 1'($urandom_range(1));
            do_cycle(e, rdy, zd, od, fd, name, got);
            if (got[6] && obs_cyc < 0) begin
                obs_cyc = i + 1;
                obs_np  = got[5:4];
            end
        end
        exp_retire++;
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, got, exp);
        end
    endtask

    typedef struct {
        string      name;
        logic [5:0] op;
        logic [5:0] funct;
        logic       zero;
        int         stalls;
        int         exp_cycles;
        logic [1:0] exp_npc;
    } vec_t;

    vec_t vecs[$];
    logic [5:0] legal_ops[13] = '{6'h00, 6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02,
                                  6'h03, 6'h08, 6'h0d, 6'h0f, 6'h00, 6'h23};
    logic [5:0] legal_fn[6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h08};

    initial begin
        int cyc;
        logic [1:0] np;
        logic [9:0] got;
        logic [5:0] o, f;

        vecs = '{
            '{"j",       6'h02, 6'h00, 1'b0, 0, 2, 2'b10},
            '{"beq_z1",  6'h04, 6'h00, 1'b1, 0, 3, 2'b01},
            '{"beq_z0",  6'h04, 6'h00, 1'b0, 0, 3, 2'b00},
            '{"bne_z1",  6'h05, 6'h00, 1'b1, 0, 3, 2'b00},
            '{"bne_z0",  6'h05, 6'h00, 1'b0, 0, 3, 2'b01},
            '{"lw",      6'h23, 6'h00, 1'b0, 0, 5, 2'b00},
            '{"sw",      6'h2b, 6'h00, 1'b1, 0, 4, 2'b00},
            '{"jr_stall",6'h00, 6'h08, 1'b0, 3, 5, 2'b11},
            '{"ill_op",  6'h3f, 6'h00, 1'b0, 0, 2, 2'b00},
            '{"ill_fn",  6'h00, 6'h01, 1'b0, 0, 2, 2'b00},
            '{"add",     6'h00, 6'h20, 1'b0, 0, 4, 2'b00},
            '{"sub",     6'h00, 6'h22, 1'b1, 0, 4, 2'b00},
            '{"and",     6'h00, 6'h24, 1'b0, 0, 4, 2'b00},
            '{"or",      6'h00, 6'h25, 1'b0, 0, 4, 2'b00},
            '{"slt",     6'h00, 6'h2a, 1'b0, 0, 4, 2'b00},
            '{"addi",    6'h08, 6'h00, 1'b0, 0, 4, 2'b00},
            '{"ori",     6'h0d, 6'h00, 1'b0, 0, 4, 2'b00},
            '{"lui",     6'h0f, 6'h00, 1'b0, 1, 5, 2'b00},
            '{"jal",     6'h03, 6'h00, 1'b0, 0, 2, 2'b10}
        };

        rst = 1'b1; op = 6'h00; funct = 6'h00; zero = 1'b0; imem_ready = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        do_cycle(mk(3'd0, 0, 2'b00, 0, 0, 0, 0), 1'b1, 1'b0, 6'h02, 6'h00, "reset_hold", got);
        rst = 1'b0;
        exp_retire = 0;
`ifdef NPC_SEQ_RETIRE_CNT_EN
        check_val("retire_after_reset", retire_cnt, 32'd0);
`endif

        // Directed table
        foreach (vecs[i]) begin
            run_instr(vecs[i].op, vecs[i].funct, vecs[i].zero, vecs[i].stalls, vecs[i].name, cyc, np);
            check_val({vecs[i].name, "_cycles"}, cyc, vecs[i].exp_cycles);
            check_val({vecs[i].name, "_npcop"}, {30'd0, np}, {30'd0, vecs[i].exp_npc});
        end

        // Reset in EXEC of an R-type: nothing fires, FETCH next cycle
        do_cycle(mk(3'd0, 0, 2'b00, 1, 0, 0, 0), 1'b1, 1'b0, 6'h00, 6'h20, "rst_exec_fetch", got);
        do_cycle(mk(3'd1, 0, 2'b00, 0, 0, 0, 0), 1'b1, 1'b0, 6'h00, 6'h20, "rst_exec_decode", got);
        rst = 1'b1;
        do_cycle(mk(3'd2, 0, 2'b00, 0, 0, 0, 0), 1'b1, 1'b1, 6'h00, 6'h20, "rst_exec_abort", got);
        rst = 1'b0;
        exp_retire = 0;
        do_cycle(mk(3'd0, 0, 2'b00, 0, 0, 0, 0), 1'b0, 1'b0, 6'h00, 6'h20, "rst_exec_after", got);
`ifdef NPC_SEQ_RETIRE_CNT_EN
        check_val("retire_cleared", retire_cnt, 32'd0);
`endif
        // Reset in DECODE of j suppresses its PCWr
        do_cycle(mk(3'd0, 0, 2'b00, 1, 0, 0, 0), 1'b1, 1'b0, 6'h02, 6'h00, "rst_dec_fetch", got);
        rst = 1'b1;
        do_cycle(mk(3'd1, 0, 2'b00, 0, 0, 0, 0), 1'b1, 1'b0, 6'h02, 6'h00, "rst_dec_abort", got);
        rst = 1'b0;
        run_instr(6'h02, 6'h00, 1'b0, 0, "post_rst_j", cyc, np);
        run_instr(6'h04, 6'h00, 1'b1, 0, "post_rst_beq", cyc, np);
        run_instr(6'h00, 6'h20, 1'b0, 0, "post_rst_add", cyc, np);
`ifdef NPC_SEQ_RETIRE_CNT_EN
        check_val("retire_three", retire_cnt, 32'd3);
`endif

        // Random instruction stream against the model
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(7) == 0) o = 6'($urandom);
            else o = legal_ops[$urandom_range(12)];
            if ($urandom_range(7) == 0) f = 6'($urandom);
            else f = legal_fn[$urandom_range(5)];
            run_instr(o, f, 1'($urandom_range(1)), $urandom_range(2), "random", cyc, np);
        end
`ifdef NPC_SEQ_RETIRE_CNT_EN
        check_val("retire_random", retire_cnt, exp_retire);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
